// File: rtl/sr_ctrl_pkg.sv
// Shared types and defaults for the SR latch controller slice.
package sr_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    GAP,
    DONE
  } state_t;

  typedef enum logic {
    OP_SET,
    OP_CLR
  } op_t;

  localparam int unsigned DEF_PULSE_W = 2;
  localparam int unsigned DEF_GAP_W   = 3;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sr_rr_arb.sv
// Combinational round-robin picker: first pending index at or after ptr, with wrap.
module sr_rr_arb #(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]         pend,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [$clog2(N_REQ)-1:0] winner,
  output logic                     valid
);

  localparam int unsigned IW = $clog2(N_REQ);

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      int unsigned idx;
      idx = (i + 32'(ptr)) % N_REQ;
      if (!valid && pend[IW'(idx)]) begin
        valid  = 1'b1;
        winner = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/sr_latch_ctrl.sv
// Arbitrates set/clear requests onto one shared NOR SR latch with registered,
// non-overlapping s/r pulses and synchronized verification of the latch state.
module sr_latch_ctrl
  import sr_ctrl_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned PULSE_W = DEF_PULSE_W,
  parameter int unsigned GAP_W   = DEF_GAP_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_set,
  input  logic [N_REQ-1:0]         req_clr,
  input  logic                     q_fb,
  output logic                     s,
  output logic                     r,
  output logic [N_REQ-1:0]         ack,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy,
  output logic                     err
);

  localparam int unsigned IW = $clog2(N_REQ);
  localparam int unsigned CW = $clog2(max2(PULSE_W, GAP_W) + 1);

  state_t          state;
  op_t             op;
  op_t             nxt_op;
  logic [CW-1:0]   cnt;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   win;
  logic            win_valid;
  logic            q_meta;
  logic            q_sync;
  logic [N_REQ-1:0] pend;

  assign pend   = req_set | req_clr;
  assign nxt_op = req_clr[win] ? OP_CLR : OP_SET;

  sr_rr_arb #(
    .N_REQ(N_REQ)
  ) u_arb (
    .pend  (pend),
    .ptr   (ptr),
    .winner(win),
    .valid (win_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op       <= OP_SET;
      cnt      <= '0;
      ptr      <= '0;
      q_meta   <= 1'b0;
      q_sync   <= 1'b0;
      s        <= 1'b0;
      r        <= 1'b0;
      ack      <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
      err      <= 1'b0;
    end else begin
      q_meta <= q_fb;
      q_sync <= q_meta;
      ack    <= '0;
      case (state)
        IDLE: begin
          if (win_valid) begin
            grant_id <= win;
            op       <= nxt_op;
            ptr      <= (win == IW'(N_REQ - 1)) ? '0 : win + 1'b1;
            busy     <= 1'b1;
            // Latch already in the target state: acknowledge without pulsing.
            if (q_sync == (nxt_op == OP_SET)) begin
              state <= DONE;
              ack   <= N_REQ'(1) << win;
            end else begin
              state <= PULSE;
              s     <= (nxt_op == OP_SET);
              r     <= (nxt_op == OP_CLR);
              cnt   <= CW'(PULSE_W - 1);
            end
          end
        end
        PULSE: begin
          if (cnt == '0) begin
            state <= GAP;
            s     <= 1'b0;
            r     <= 1'b0;
            cnt   <= CW'(GAP_W - 1);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GAP: begin
          if (cnt == '0) begin
            if (q_sync != (op == OP_SET)) err <= 1'b1;
            state <= DONE;
            ack   <= N_REQ'(1) << grant_id;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sr_latch_ctrl.sv
// Bench for sr_latch_ctrl: behavioural NOR latch, transaction-level timing model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_sr_latch_ctrl;

  localparam int N = 4;
  localparam int P = 2;
  localparam int G = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req_set = '0;
  logic [3:0] req_clr = '0;
  logic       q_fb;
  logic       s, r, busy, err;
  logic [3:0] ack;
  logic [1:0] grant_id;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sr_latch_ctrl #(
    .N_REQ  (N),
    .PULSE_W(P),
    .GAP_W  (G)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_set (req_set),
    .req_clr (req_clr),
    .q_fb    (q_fb),
    .s       (s),
    .r       (r),
    .ack     (ack),
    .grant_id(grant_id),
    .busy    (busy),
    .err     (err)
  );

  // Behavioural NOR latch; the bench may overwrite its state while s=r=0.
  logic lq = 1'b0;
  logic stuck = 1'b0;
  logic fq_val = 1'b0;
  int   fq_cnt = 0;
  int   fq_seen = 0;
  always @(s, r, fq_cnt) begin
    if (fq_cnt != fq_seen) begin
      fq_seen = fq_cnt;
      lq = fq_val;
    end else if (s && !r) lq = 1'b1;
    else if (r && !s) lq = 1'b0;
  end
  assign q_fb = stuck ? 1'b0 : lq;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // q_fb as the DUT will see it at the next rising edge.
  logic qfb_pre = 1'b0;
  always @(negedge clk) begin
    #2;
    qfb_pre = q_fb;
  end

  // Transaction model: one grant record, outputs derived from edges since grant.
  int   e = 0, k = 0, m_win = 0, m_ptr = 0;
  bit   has_g = 0, m_set = 0, m_skip = 0, m_err = 0;
  logic h1 = 1'b0, h2 = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e = 0; k = 0; has_g = 0; m_ptr = 0; m_err = 0; h1 = 0; h2 = 0;
    end else begin
      logic       qs;
      logic [3:0] pend;
      bit         found;
      int         d;
      qs = h2; h2 = h1; h1 = qfb_pre;
      e++;
      d = e - k;
      if (has_g && !m_skip && d == P + G && qs != m_set) m_err = 1;
      if (!has_g || d >= (m_skip ? 2 : P + G + 2)) begin
        pend  = req_set | req_clr;
        found = 0;
        for (int i = 0; i < N; i++) begin
          int j;
          j = (m_ptr + i) % N;
          if (!found && pend[j]) begin
            found  = 1;
            m_win  = j;
            m_set  = !req_clr[j];
            m_skip = (qs == m_set);
            k      = e;
            has_g  = 1;
            m_ptr  = (j + 1) % N;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      int d;
      bit xb, xs, xr;
      logic [3:0] xa;
      d = e - k;
      xb = 0; xs = 0; xr = 0; xa = '0;
      if (has_g) begin
        if (m_skip) begin
          xb = (d == 0);
          if (d == 0) xa = 4'(1) << m_win;
        end else begin
          xb = (d <= P + G);
          xs = m_set && (d < P);
          xr = !m_set && (d < P);
          if (d == P + G) xa = 4'(1) << m_win;
        end
      end
      chk("busy", int'(busy), int'(xb));
      chk("s", int'(s), int'(xs));
      chk("r", int'(r), int'(xr));
      chk("ack", int'(ack), int'(xa));
      chk("err", int'(err), int'(m_err));
      chk("s_and_r", int'(s & r), 0);
      if (xb) chk("grant_id", int'(grant_id), m_win);
    end
  end

  task automatic force_q(input logic v);
    fq_val = v;
    fq_cnt++;
  endtask

  task automatic wait_ack(output int n, output logic [3:0] a, output int sc, output int rc);
    n = 0; a = '0; sc = 0; rc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (s) sc++;
      if (r) rc++;
      if (ack != '0) begin
        a = ack;
        return;
      end
    end
    n = 99;
  endtask

  initial begin
    int n, sc, rc;
    logic [3:0] a;
    logic [3:0] rr_exp [5];
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    repeat (3) @(negedge clk);
    chk("rst_s", int'(s), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ack", int'(ack), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_grant", int'(grant_id), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single set from q=0
    req_set = 4'b0001;
    wait_ack(n, a, sc, rc);
    req_set = '0;
    chk("set_lat", n, 6);
    chk("set_ack", int'(a), 1);
    chk("set_spulse", sc, 2);
    chk("set_rpulse", rc, 0);
    chk("set_err", int'(err), 0);
    repeat (3) @(negedge clk);

    // Skip path: latch already set
    req_set = 4'b0100;
    wait_ack(n, a, sc, rc);
    req_set = '0;
    chk("skip_lat", n, 1);
    chk("skip_ack", int'(a), 4);
    chk("skip_pulse", sc + rc, 0);
    repeat (3) @(negedge clk);

    // Stuck latch
    stuck = 1'b1;
    repeat (3) @(negedge clk);
    req_set = 4'b1000;
    wait_ack(n, a, sc, rc);
    req_set = '0;
    chk("stuck_lat", n, 6);
    chk("stuck_ack", int'(a), 8);
    chk("stuck_spulse", sc, 2);
    chk("stuck_err", int'(err), 1);
    stuck = 1'b0;
    repeat (3) @(negedge clk);

    // Round-robin with all requesters clearing, q toggled back between ops
    req_clr = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_ack(n, a, sc, rc);
      chk("rr_ack", int'(a), int'(rr_exp[i]));
      req_clr = req_clr & ~a;
      if (i == 2) req_clr[0] = 1'b1;
      force_q(1'b1);
    end
    req_clr = '0;
    chk("rr_err_sticky", int'(err), 1);
    repeat (3) @(negedge clk);

    // Conflicting request: clear wins
    req_set = 4'b0010;
    req_clr = 4'b0010;
    wait_ack(n, a, sc, rc);
    req_set = '0;
    req_clr = '0;
    chk("conf_lat", n, 6);
    chk("conf_ack", int'(a), 2);
    chk("conf_rpulse", rc, 2);
    chk("conf_spulse", sc, 0);
    repeat (3) @(negedge clk);

    // Reset in the second PULSE cycle
    req_set = 4'b0001;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_s", int'(s), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_ack", int'(ack), 0);
    chk("abort_err", int'(err), 0);
    req_set = '0;
    @(negedge clk);
    rst_n = 1'b1;
    sc = 0;
    repeat (10) begin
      @(negedge clk);
      if (ack != '0) sc++;
    end
    chk("abort_no_ack", sc, 0);
    chk("abort_qsync", int'(dut.q_sync), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
